// File: rtl/vga_rect_display.sv
// rtl/vga_rect_display.sv - 640x480 VGA timing with a fixed red square and a key-driven green square
module vga_rect_display #(
    parameter int STEP    = 4,
    parameter int SIZE    = 64,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int A_X0    = 100,
    parameter int A_X1    = 199,
    parameter int A_Y0    = 100,
    parameter int A_Y1    = 199,
    parameter int PX_INIT = 288,
    parameter int PY_INIT = 208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic       vsync,
    output logic       hsync,
    output logic [2:0] rgb
);

    localparam logic [9:0]  H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  H_VIS_L   = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_L   = 10'(V_VIS);
    localparam logic [9:0]  HS_START  = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END    = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0]  A_X0_L    = 10'(A_X0);
    localparam logic [9:0]  A_X1_L    = 10'(A_X1);
    localparam logic [9:0]  A_Y0_L    = 10'(A_Y0);
    localparam logic [9:0]  A_Y1_L    = 10'(A_Y1);
    localparam logic [10:0] SIZE_L    = 11'(SIZE);
    localparam logic [10:0] X_MAX     = 11'(H_VIS - SIZE);
    localparam logic [9:0]  X_MAX10   = 10'(H_VIS - SIZE);
    localparam logic [10:0] STEP_X    = 11'(STEP);
    localparam logic [9:0]  STEP_X10  = 10'(STEP);
    localparam logic [9:0]  Y_MAX     = 10'(V_VIS - SIZE);
    localparam logic [8:0]  Y_MAX9    = 9'(V_VIS - SIZE);
    localparam logic [9:0]  STEP_Y    = 10'(STEP);
    localparam logic [8:0]  STEP_Y9   = 9'(STEP);
    localparam logic [9:0]  PX_RST    = 10'(PX_INIT);
    localparam logic [8:0]  PY_RST    = 9'(PY_INIT);

    logic       phase;
    logic       pix_en;
    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] px;
    logic [8:0] py;

    // pix_en is high on the first clk after reset, then every second clk
    assign pix_en = ~phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
        end
    end

    logic       visible;
    logic       in_a;
    logic       in_b;
    logic [2:0] pix_rgb;

    always_comb begin
        visible = (hc < H_VIS_L) && (vc < V_VIS_L);
        in_a    = (hc >= A_X0_L) && (hc <= A_X1_L) && (vc >= A_Y0_L) && (vc <= A_Y1_L);
        in_b    = ({1'b0, hc} >= {1'b0, px}) && ({1'b0, hc} < ({1'b0, px} + SIZE_L)) &&
                  ({1'b0, vc} >= {2'b00, py}) && ({1'b0, vc} < ({2'b00, py} + SIZE_L));
        pix_rgb = visible ? {in_a, in_b, ~(in_a | in_b)} : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 3'b000;
        end else if (pix_en) begin
            hsync <= ~((hc >= HS_START) && (hc < HS_END));
            vsync <= ~((vc >= VS_START) && (vc < VS_END));
            rgb   <= pix_rgb;
        end
    end

    // Sums are one bit wider than the register so overflow is seen before clamping
    logic [10:0] px_sum;
    logic [9:0]  px_up;
    logic [9:0]  px_dn;
    logic [9:0]  px_next;
    logic [9:0]  py_sum;
    logic [8:0]  py_up;
    logic [8:0]  py_dn;
    logic [8:0]  py_next;
    logic        frame_tick;

    always_comb begin
        px_sum = {1'b0, px} + STEP_X;
        px_up  = (px_sum > X_MAX) ? X_MAX10 : px_sum[9:0];
        px_dn  = ({1'b0, px} < STEP_X) ? 10'd0 : px - STEP_X10;
        py_sum = {1'b0, py} + STEP_Y;
        py_up  = (py_sum > Y_MAX) ? Y_MAX9 : py_sum[8:0];
        py_dn  = ({1'b0, py} < STEP_Y) ? 9'd0 : py - STEP_Y9;

        px_next = px;
        if (key[0] && !key[1]) begin
            px_next = px_up;
        end else if (key[1] && !key[0]) begin
            px_next = px_dn;
        end

        py_next = py;
        if (key[2] && !key[3]) begin
            py_next = py_up;
        end else if (key[3] && !key[2]) begin
            py_next = py_dn;
        end

        frame_tick = pix_en && (hc == 10'd0) && (vc == V_VIS_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px <= PX_RST;
            py <= PY_RST;
        end else if (frame_tick) begin
            px <= px_next;
            py <= py_next;
        end
    end

endmodule

// File: tb/tb_vga_rect_display.sv
// tb/tb_vga_rect_display.sv - randomized key stimulus against a pixel-index model of the display
module tb_vga_rect_display;

    localparam int STEP = 2, SIZE = 6;
    localparam int HV = 24, HF = 2, HS = 3, HB = 3, HT = HV + HF + HS + HB;
    localparam int VV = 16, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
    localparam int AX0 = 3, AX1 = 7, AY0 = 3, AY1 = 7;
    localparam int PX0 = 10, PY0 = 6;
    localparam int FRAME_CLK = 2 * HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'b0000;
    logic       vsync, hsync;
    logic [2:0] rgb;
    logic       d_vsync, d_hsync;
    logic [2:0] d_rgb;

    int n_chk  = 0;
    int n_fail = 0;

    vga_rect_display #(
        .STEP(STEP), .SIZE(SIZE),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .A_X0(AX0), .A_X1(AX1), .A_Y0(AY0), .A_Y1(AY1),
        .PX_INIT(PX0), .PY_INIT(PY0)
    ) dut (
        .clk(clk), .rst(rst), .key(key),
        .vsync(vsync), .hsync(hsync), .rgb(rgb)
    );

    vga_rect_display dflt (
        .clk(clk), .rst(rst), .key(4'b0000),
        .vsync(d_vsync), .hsync(d_hsync), .rgb(d_rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_rgb(input int x, input int y, input int px, input int py);
        bit a, b;
        if (x >= HV || y >= VV) return 0;
        a = (x >= AX0 && x <= AX1 && y >= AY0 && y <= AY1);
        b = (x >= px && x < px + SIZE && y >= py && y < py + SIZE);
        return {29'd0, a, b, !(a || b)};
    endfunction

    function automatic int move(input int pos, input bit plus, input bit minus, input int max);
        int r = pos;
        if (plus && !minus) r = r + STEP;
        else if (minus && !plus) r = r - STEP;
        if (r < 0) r = 0;
        if (r > max) r = max;
        return r;
    endfunction

    int n = 0;
    int mpx = PX0, mpy = PY0;
    bit pin_mode = 0, seq_mode = 0, dflt_on = 0;
    int seq_idx = 0;
    int seq_exp [3] = '{12, 14, 16};
    int pin_x [4] = '{4, 12, 1, 26};
    int pin_y [4] = '{4, 8, 1, 1};
    int pin_c [4] = '{4, 2, 1, 0};
    logic d_h_prev = 1'b1;
    int d_first_fall = 0, d_last_fall = 0;

    // One compare process: outputs after clock n (since release) show pixel (n-1)/2
    always @(negedge clk) begin
        int p, x, y, frame, pd;
        if (rst) begin
            n = 0;
            mpx = PX0;
            mpy = PY0;
            chk("rst_hsync", hsync, 1);
            chk("rst_vsync", vsync, 1);
            chk("rst_rgb", rgb, 0);
            chk("rst_dflt_hsync", d_hsync, 1);
            chk("rst_dflt_rgb", d_rgb, 0);
            d_h_prev = 1'b1;
            d_first_fall = 0;
        end else begin
            n++;
            p = (n - 1) / 2;
            x = p % HT;
            y = (p / HT) % VT;
            frame = p / (HT * VT);
            chk("rgb", rgb, model_rgb(x, y, mpx, mpy));
            chk("hsync", hsync, (x >= HV + HF && x < HV + HF + HS) ? 0 : 1);
            chk("vsync", vsync, (y >= VV + VF && y < VV + VF + VS) ? 0 : 1);
            if (n % 2 == 1) begin
                if (pin_mode && frame == 0)
                    for (int i = 0; i < 4; i++)
                        if (x == pin_x[i] && y == pin_y[i]) chk("pin_frame0", rgb, pin_c[i]);
                if (x == 4 && y == 6 && mpx == 0 && mpy == 6) chk("pin_overlap", rgb, 6);
                if (x == 0 && y == VV) begin
                    mpx = move(mpx, key[0], key[1], HV - SIZE);
                    mpy = move(mpy, key[2], key[3], VV - SIZE);
                    if (seq_mode && seq_idx < 3) begin
                        chk("px_seq", mpx, seq_exp[seq_idx]);
                        seq_idx++;
                    end
                end
            end
            if (dflt_on) begin
                pd = (n - 1) / 2;
                if (n == 1) chk("dflt_rgb_0_0", d_rgb, 1);
                if (n == 21) chk("dflt_rgb_10_0", d_rgb, 1);
                if (n == 1401) chk("dflt_rgb_700_0", d_rgb, 0);
                chk("dflt_vsync", d_vsync, 1);
                if (d_h_prev && !d_hsync) begin
                    if (d_first_fall == 0) begin
                        chk("dflt_hsync_first_fall", n, 1313);
                        d_first_fall = n;
                    end else begin
                        chk("dflt_hsync_period", n - d_last_fall, 1600);
                    end
                    d_last_fall = n;
                end
                if (!d_h_prev && d_hsync) chk("dflt_hsync_low", n - d_last_fall, 192);
                if (pd % 800 == 0 && n % 2 == 1 && pd > 0) chk("dflt_line_rgb", d_rgb, 1);
                d_h_prev = d_hsync;
            end
        end
    end

    task automatic run(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        #1 rst = 1'b1;
        run(k);
        rst = 1'b0;
    endtask

    task automatic run_random_pulses(input int frames);
        for (int f = 0; f < frames; f++) begin
            run(100 + $urandom_range(0, 50));
            key = 4'($urandom_range(1, 15));
            run(600);
            key = 4'b0000;
            run(FRAME_CLK - 700 - 50 + 50);
            run(0);
        end
    endtask

    initial begin
        int off;
        // Step 1: +x for three updates, plus default-geometry line timing
        key = 4'b0001;
        run(4);
        pin_mode = 1;
        seq_mode = 1;
        dflt_on  = 1;
        rst = 1'b0;
        run(3 * FRAME_CLK);
        key = 4'b0000;
        run(FRAME_CLK);
        pin_mode = 0;
        seq_mode = 0;
        dflt_on  = 0;
        chk("model_px_after_3", mpx, 16);
        chk("model_py_after_3", mpy, 6);
        chk("px_seq_count", seq_idx, 3);

        // Step 2: -x from reset clamps at 0 and stays there
        key = 4'b0010;
        do_reset(2);
        run(9 * FRAME_CLK);
        chk("model_px_floor", mpx, 0);

        // Step 3: +x and +y until both clamp
        key = 4'b0101;
        do_reset(2);
        run(12 * FRAME_CLK);
        chk("model_px_ceiling", mpx, 18);
        chk("model_py_ceiling", mpy, 10);

        // Step 4: opposing keys, then random key pulses that avoid update points
        key = 4'b0011;
        run(2 * FRAME_CLK);
        key = 4'b1111;
        run(FRAME_CLK);
        for (int f = 0; f < 2; f++) begin
            off = 100 + int'($urandom_range(0, 50));
            key = 4'b0000;
            run(off);
            key = 4'($urandom_range(1, 15));
            run(900 - off);
            key = 4'b0000;
            run(FRAME_CLK - 900);
        end
        chk("model_px_hold", mpx, 18);
        chk("model_py_hold", mpy, 10);

        // Step 5: reset mid-frame at pixel (12,8), held for a while
        run(537);
        rst = 1'b1;
        run(20);
        rst = 1'b0;
        chk("model_px_after_rst", mpx, PX0);
        chk("model_py_after_rst", mpy, PY0);

        // Step 6: random held keys, one per frame
        for (int f = 0; f < 6; f++) begin
            key = 4'($urandom_range(0, 15));
            run(FRAME_CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_rect_display.md
VGA_RECT_DISPLAY -- requirements
Module: vga_rect_display

Interface
REQ-001 SHALL have parameter STEP, default 4, pixels moved per frame per held key.
REQ-002 SHALL have parameter SIZE, default 64, side length in pixels of the movable square.
REQ-003 SHALL have port clk, input, 1, 50 MHz system clock; all flops on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port key, input, 4, debounced active-high keys: [0] +x, [1] -x, [2] +y, [3] -y.
REQ-006 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-007 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-008 SHALL have port rgb, output, 3, pixel colour, bit 2 = R, bit 1 = G, bit 0 = B, active high.

Function
REQ-009 SHALL generate pix_en on every second clk (25 MHz pixel rate); pix_en is high on the first clk after reset release.
REQ-010 SHALL keep counters hc 0..799 and vc 0..524, advancing only on pix_en.
REQ-011 SHALL wrap hc from 799 to 0 and then increment vc; vc SHALL wrap from 524 to 0.
REQ-012 SHALL define horizontal timing as visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-013 SHALL define vertical timing as visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-014 SHALL drive hsync low exactly for hc 656..751 and vsync low exactly for vc 490..491.
REQ-015 SHALL register hsync, vsync and rgb, and update them only on pix_en cycles.
REQ-016 SHALL make the registered outputs reflect the hc/vc value present at that pix_en; latency is one pixel.
REQ-017 SHALL force rgb = 000 outside the visible area (hc >= 640 or vc >= 480).
REQ-018 SHALL, in the visible area, set B = 1 when the pixel is inside neither rectangle and B = 0 otherwise.
REQ-019 SHALL set R = 1 inside fixed square A: 100 <= hc <= 199 and 100 <= vc <= 199.
REQ-020 SHALL set G = 1 inside movable square B: px <= hc < px+SIZE and py <= vc < py+SIZE.
REQ-021 SHALL show an A/B overlap as rgb = 110.
REQ-022 SHALL hold position registers px (10 bit) and py (9 bit), reset to px = 288 and py = 208.
REQ-023 SHALL update px/py only on the pix_en cycle where hc = 0 and vc = 480 (once per frame, start of vblank).
REQ-024 SHALL sample key at that update cycle only; key changes at other times have no effect until the next update.
REQ-025 SHALL move px by +STEP for key[0] alone, by -STEP for key[1] alone, and not at all when both or neither are set.
REQ-026 SHALL apply the same rule as REQ-025 to py using key[2] (+STEP) and key[3] (-STEP).
REQ-027 SHALL clamp px to 0..640-SIZE and py to 0..480-SIZE, with no wrap-around.
REQ-028 SHALL detect underflow before subtraction: px < STEP with -x gives px = 0.
REQ-029 SHALL update the x and y axes independently in the same cycle.
REQ-030 SHALL keep position arithmetic one bit wider than the position register to detect overflow before clamping.

Reset
REQ-031 SHALL, on a cycle with rst = 1, set hc = 0, vc = 0 and pix_en phase = 0.
REQ-032 SHALL, on a cycle with rst = 1, set hsync = 1, vsync = 1 and rgb = 000.
REQ-033 SHALL, on a cycle with rst = 1, set px = 288 and py = 208.
REQ-034 SHALL restart timing from hc = 0, vc = 0 when reset is asserted mid-frame.
REQ-035 SHALL keep all outputs at their reset values for as long as rst stays high.

Verification
REQ-036 SHALL cover: reset released, keys idle -> hsync period 1600 clk with 192 clk low; vsync period 840000 clk with 3200 clk low.
REQ-037 SHALL cover: frame 0 visible scan -> rgb 100 at (150,150), 010 at (300,220), 001 at (10,10), 000 at (700,10).
REQ-038 SHALL cover: key = 0001 held for 3 frames -> px 288, 292, 296, 300 at successive vblanks; py unchanged.
REQ-039 SHALL cover: key = 0010 held for 80 frames from reset -> px reaches 0 and stays 0; no wrap to a large value.
REQ-040 SHALL cover: key = 0101 held until clamp -> px = 576, py = 416.
REQ-041 SHALL cover: key = 0011 held, and key pulsed between update points only -> px/py unchanged; rst pulsed at hc = 400, vc = 300 -> counters restart at 0 and px = 288.
